adc0809_scan_ctrl: RTL
======================

// Module: adc0809_scan_ctrl
// PURPOSE
//   Multi-channel scanning controller for the ADC0809CCN (VREF 5 V). Generates the ADC clock,
//   drives ADDR A/B/C, ALE, START and OE, and tracks EOC. It converts every channel enabled in
//   ch_mask, in single-shot or continuous mode, and presents each result with its channel
//   number as a one-cycle valid pulse. Sits between the ADC0809 pins and the sample consumer.
// PARAMETERS
//   CLK_DIV      28    clk cycles per adc_clk half-period (27 MHz -> ~482 kHz); min 1
//   PULSE_W      4     clk cycles each for addr setup, ALE high and START high; min 1
//   OE_WAIT      3     clk cycles OE is high before adc_d is sampled; min 1
//   EOC_FALL_MAX 64    max clk cycles after START falls for EOC to go low
//   EOC_TIMEOUT  8192  max clk cycles with EOC low before the conversion is abandoned
// PORTS
//   clk           in   1  system clock, 27 MHz
//   rst_n         in   1  asynchronous reset, active low
//   en            in   1  block enable; low aborts any activity
//   continuous    in   1  1: rescan forever; 0: one pass per trig
//   trig          in   1  single-cycle pulse; starts one pass when idle and continuous=0
//   ch_mask       in   8  bit i set = convert channel i
//   adc_clk       out  1  ADC0809 CLOCK pin
//   adc_addr      out  3  ADC0809 ADD C/B/A
//   ale           out  1  address latch enable
//   start         out  1  conversion start
//   eoc           in   1  end of conversion (asynchronous; 2-flop synchronised inside)
//   oe            out  1  output enable
//   adc_d         in   8  ADC0809 D7..D0
//   sample_data   out  8  converted value
//   sample_ch     out  3  channel of sample_data
//   sample_valid  out  1  one-cycle pulse; sample_data and sample_ch valid
//   busy          out  1  high in every state except IDLE
//   timeout_err   out  1  one-cycle pulse on an EOC fall or rise timeout
// BEHAVIOUR
//   Reset: all outputs 0; adc_addr=0; state IDLE; divider counter 0.
//   adc_clk: free-running toggle every CLK_DIV clk cycles while en=1; held 0 while en=0.
//   eoc passes through a 2-flop synchroniser (eoc_s) before any use.
//   FSM (all timing in clk cycles):
//     IDLE     enter a pass on en & |ch_mask & (continuous | trig); cur_ch = lowest set bit
//     SETUP    adc_addr=cur_ch, held for PULSE_W cycles
//     ALE_P    ale=1 for PULSE_W cycles
//     START_P  start=1 for PULSE_W cycles; ale drops to 0 on entry
//     WAIT_L   wait for eoc_s=0; if not seen in EOC_FALL_MAX cycles -> timeout_err, go to NEXT
//     WAIT_H   wait for eoc_s=1; if not seen in EOC_TIMEOUT cycles -> timeout_err, go to NEXT
//     OE_ON    oe=1 for OE_WAIT cycles
//     CAPTURE  latch adc_d into sample_data and cur_ch into sample_ch; sample_valid=1 for one cycle; oe=0
//     NEXT     next set bit of ch_mask above cur_ch
//              - found: cur_ch = that bit, go to SETUP
//              - none: continuous=1 wraps to the lowest set bit and goes to SETUP; otherwise IDLE
//   adc_addr holds its value from SETUP until the next SETUP.
//   ch_mask is sampled only in IDLE and NEXT; a change mid-conversion does not affect it.
//   ch_mask=0: no conversion starts and busy stays 0; in NEXT, mask=0 goes to IDLE.
//   trig while busy is ignored; trig while continuous=1 has no effect.
//   en=0 in any state: next cycle go to IDLE; ale, start and oe go to 0; no sample_valid.
//   A timed-out channel produces no sample_valid; the scan continues with the next channel.
//   rst_n asserted mid-conversion: immediate reset values; the ADC result is discarded.
// TESTING
//   T1 ch_mask=8'h08, trig, eoc model 0x5A -> adc_addr=3; ale then start pulses of 4 clk each;
//      one sample_valid with data 0x5A, ch 3; busy then 0.
//   T2 ch_mask=8'h81, continuous=1, model returns 0x10+ch -> valid sequence ch0=0x10, ch7=0x17,
//      ch0=0x10 ... with the wrap from 7 to 0.
//   T3 eoc stuck high after start -> timeout_err after 64 cycles; no sample_valid; next channel
//      starts.
//   T4 eoc falls but never rises -> timeout_err after 8192 cycles; scan continues.
//   T5 en dropped during WAIT_H -> IDLE next cycle; ale=start=oe=0; no valid; adc_clk=0.
//   T6 ch_mask=0 with trig -> busy stays 0; no ale/start. trig asserted during a pass -> ignored.

Source files
------------

// File: rtl/adc0809_scan_ctrl.sv
// adc0809_scan_ctrl
//   Multi-channel scan controller for an ADC0809 converter. It generates the
//   converter clock, sequences address/ALE/START, tracks EOC, enables the
//   output drivers and returns each result tagged with its channel number.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             block enable; low aborts any activity and stops adc_clk
//   continuous     1: rescan the channel set forever; 0: one pass per trig
//   trig           single-cycle pass request (used only when idle, continuous=0)
//   ch_mask[7:0]   bit i set = convert channel i
//   adc_clk        ADC0809 CLOCK pin
//   adc_addr[2:0]  ADC0809 ADD C/B/A
//   ale, start, oe ADC0809 control pins
//   eoc            ADC0809 end of conversion (asynchronous)
//   adc_d[7:0]     ADC0809 data bus
//   sample_data    converted value
//   sample_ch      channel of sample_data
//   sample_valid   one-cycle pulse qualifying sample_data/sample_ch
//   busy           high whenever a pass is in progress
//   timeout_err    one-cycle pulse when EOC fails to fall or to rise in time
module adc0809_scan_ctrl #(
    parameter int CLK_DIV      = 28,
    parameter int PULSE_W      = 4,
    parameter int OE_WAIT      = 3,
    parameter int EOC_FALL_MAX = 64,
    parameter int EOC_TIMEOUT  = 8192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       continuous,
    input  logic       trig,
    input  logic [7:0] ch_mask,
    output logic       adc_clk,
    output logic [2:0] adc_addr,
    output logic       ale,
    output logic       start,
    input  logic       eoc,
    output logic       oe,
    input  logic [7:0] adc_d,
    output logic [7:0] sample_data,
    output logic [2:0] sample_ch,
    output logic       sample_valid,
    output logic       busy,
    output logic       timeout_err
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int MAX_A  = (PULSE_W > OE_WAIT) ? PULSE_W : OE_WAIT;
    localparam int MAX_B  = (EOC_TIMEOUT > EOC_FALL_MAX) ? EOC_TIMEOUT : EOC_FALL_MAX;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        ALE_P,
        START_P,
        WAIT_L,
        WAIT_H,
        OE_ON,
        CAPTURE,
        NEXT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       cur_ch;
    logic [2:0]       cur_ch_next;
    logic             tmo_next;
    logic             capture_now;
    logic [DIV_W-1:0] div_cnt;
    logic             eoc_m;
    logic             eoc_s;
    logic [3:0]       low_hit;
    logic [3:0]       above_hit;

    // Lowest set bit of mask at index >= from; result is {found, index}.
    function automatic logic [3:0] first_at_or_above(input logic [7:0] mask,
                                                     input logic [3:0] from);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

    assign low_hit   = first_at_or_above(ch_mask, 4'd0);
    assign above_hit = first_at_or_above(ch_mask, {1'b0, cur_ch} + 4'd1);
    assign busy      = (state != IDLE);

    // Converter clock: toggles every CLK_DIV cycles, parked low while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // EOC idles high on the ADC0809, so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eoc_m <= 1'b1;
            eoc_s <= 1'b1;
        end else begin
            eoc_m <= eoc;
            eoc_s <= eoc_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            cur_ch <= 3'd0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            cur_ch <= cur_ch_next;
        end
    end

    always_comb begin
        state_next  = state;
        cur_ch_next = cur_ch;
        tmo_next    = 1'b0;
        capture_now = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (low_hit[3] && (continuous || trig)) begin
                        cur_ch_next = low_hit[2:0];
                        state_next  = SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(PULSE_W - 1)) state_next = ALE_P;
                end
                ALE_P: begin
                    if (cnt == CNT_W'(PULSE_W - 1)) state_next = START_P;
                end
                START_P: begin
                    if (cnt == CNT_W'(PULSE_W - 1)) state_next = WAIT_L;
                end
                WAIT_L: begin
                    if (!eoc_s) begin
                        state_next = WAIT_H;
                    end else if (cnt == CNT_W'(EOC_FALL_MAX - 1)) begin
                        tmo_next   = 1'b1;
                        state_next = NEXT;
                    end
                end
                WAIT_H: begin
                    if (eoc_s) begin
                        state_next = OE_ON;
                    end else if (cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
                        tmo_next   = 1'b1;
                        state_next = NEXT;
                    end
                end
                OE_ON: begin
                    // Data is taken on the last OE cycle, while the
                    // converter is still driving the bus.
                    if (cnt == CNT_W'(OE_WAIT - 1)) begin
                        capture_now = 1'b1;
                        state_next  = CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_next = NEXT;
                end
                NEXT: begin
                    if (above_hit[3]) begin
                        cur_ch_next = above_hit[2:0];
                        state_next  = SETUP;
                    end else if (continuous && low_hit[3]) begin
                        cur_ch_next = low_hit[2:0];
                        state_next  = SETUP;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
        // Every state measures its dwell time from zero on entry.
        cnt_next = (state_next != state) ? '0 : cnt + 1'b1;
    end

    // Pin and result registers follow the next state so each pulse lines up
    // exactly with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_addr     <= 3'd0;
            ale          <= 1'b0;
            start        <= 1'b0;
            oe           <= 1'b0;
            sample_data  <= 8'd0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            ale          <= (state_next == ALE_P);
            start        <= (state_next == START_P);
            oe           <= (state_next == OE_ON);
            sample_valid <= (state_next == CAPTURE);
            timeout_err  <= tmo_next;
            if ((state_next == SETUP) && (state != SETUP)) begin
                adc_addr <= cur_ch_next;
            end
            if (capture_now) begin
                sample_data <= adc_d;
                sample_ch   <= cur_ch;
            end
        end
    end

endmodule
